// File: rtl/v9_parameter.sv
// Shared parameters and types for the v9 shaping chain.
// Holds the peak-finder defaults, the event record and the FSM state type.
package v9_parameter;

  localparam int unsigned SIZE_ADC_DATA    = 16;
  localparam int unsigned V9_TS_W          = 32;
  localparam int unsigned V9_PK_THRESHOLD  = 100;
  localparam int unsigned V9_PK_HYST       = 8;
  localparam int unsigned V9_PK_DEAD_TIME  = 16;
  localparam int unsigned V9_PK_FIFO_DEPTH = 4;

  typedef struct packed {
    logic [SIZE_ADC_DATA-1:0] amplitude;
    logic [V9_TS_W-1:0]       timestamp;
  } v9_pk_event_t;

  typedef enum logic [1:0] {
    PK_IDLE,
    PK_ARMED,
    PK_DEAD
  } v9_pk_state_t;

  // Release level, clamped at zero so a large hysteresis cannot underflow.
  function automatic int unsigned v9_pk_release(input int unsigned thr, input int unsigned hyst);
    return (thr > hyst) ? (thr - hyst) : 0;
  endfunction

endpackage

// File: rtl/v9_event_fifo.sv
// First-word-fall-through event FIFO; pointers carry one extra wrap bit
// so full and empty are distinguishable without a separate counter.
module v9_event_fifo
  import v9_parameter::*;
#(
  parameter int unsigned DEPTH = V9_PK_FIFO_DEPTH,
  parameter type         T     = v9_pk_event_t
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  T     wdata,
  input  logic pop,
  output T     rdata,
  output logic full,
  output logic empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  T              mem_q [DEPTH];
  T              mem_d [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic          do_pop;

  assign empty  = (wptr_q == rptr_q);
  assign full   = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_pop = pop && !empty;
  assign rdata  = mem_q[rptr_q[AW-1:0]];

  // The parent only pushes when full if it pops in the same cycle, so the
  // write then lands in the slot being vacated.
  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push) begin
      mem_d[wptr_q[AW-1:0]] = wdata;
      wptr_d                = wptr_q + PW'(1);
    end
    if (do_pop) begin
      rptr_d = rptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      mem_q  <= '{default: '0};
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      mem_q  <= mem_d;
    end
  end

endmodule

// File: rtl/v9_peak_finder.sv
// Threshold/hysteresis pulse detector on the shaped v9 stream; records each
// pulse's peak amplitude and timestamp and queues it for readout.
module v9_peak_finder
  import v9_parameter::*;
#(
  parameter int unsigned DATA_W     = SIZE_ADC_DATA,
  parameter int unsigned TS_W       = V9_TS_W,
  parameter int unsigned THRESHOLD  = V9_PK_THRESHOLD,
  parameter int unsigned HYST       = V9_PK_HYST,
  parameter int unsigned DEAD_TIME  = V9_PK_DEAD_TIME,
  parameter int unsigned FIFO_DEPTH = V9_PK_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] input_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_amplitude,
  output logic [TS_W-1:0]   out_timestamp,
  output logic              overflow,
  output logic [15:0]       drop_count,
  output logic [15:0]       event_count
);

  localparam int unsigned       Release = v9_pk_release(THRESHOLD, HYST);
  localparam logic [DATA_W-1:0] ThrV    = DATA_W'(THRESHOLD);
  localparam logic [DATA_W-1:0] RelV    = DATA_W'(Release);
  localparam int unsigned       DcntW   = (DEAD_TIME > 0) ? $clog2(DEAD_TIME + 1) : 1;

  typedef struct packed {
    logic [DATA_W-1:0] amplitude;
    logic [TS_W-1:0]   timestamp;
  } pk_event_t;

  v9_pk_state_t      state_q, state_d;
  logic [TS_W-1:0]   ts_cnt_q, ts_cnt_d;
  logic [DATA_W-1:0] x_q, x_d;
  logic [TS_W-1:0]   xts_q, xts_d;
  logic [DATA_W-1:0] pk_q, pk_d;
  logic [TS_W-1:0]   pk_ts_q, pk_ts_d;
  logic [DcntW-1:0]  dcnt_q, dcnt_d;
  logic              overflow_q, overflow_d;
  logic [15:0]       drop_q, drop_d;
  logic [15:0]       evcnt_q, evcnt_d;

  logic      push_req, fifo_push, fifo_pop, fifo_full, fifo_empty;
  pk_event_t fifo_wdata, fifo_rdata;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= PK_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      PK_IDLE: begin
        if (x_q >= ThrV) state_d = PK_ARMED;
      end
      PK_ARMED: begin
        if (x_q < RelV) state_d = (DEAD_TIME == 0) ? PK_IDLE : PK_DEAD;
      end
      PK_DEAD: begin
        if ((dcnt_q == '0) && (x_q < ThrV)) state_d = PK_IDLE;
      end
      default: state_d = PK_IDLE;
    endcase
  end

  // FSM outputs: peak tracking, dead-time counter and event push request.
  always_comb begin
    pk_d     = pk_q;
    pk_ts_d  = pk_ts_q;
    dcnt_d   = dcnt_q;
    push_req = 1'b0;
    unique case (state_q)
      PK_IDLE: begin
        if (x_q >= ThrV) begin
          pk_d    = x_q;
          pk_ts_d = xts_q;
        end
      end
      PK_ARMED: begin
        if (x_q > pk_q) begin
          pk_d    = x_q;
          pk_ts_d = xts_q;
        end
        if (x_q < RelV) begin
          push_req = 1'b1;
          dcnt_d   = DcntW'(DEAD_TIME);
        end
      end
      PK_DEAD: begin
        if (dcnt_q != '0) dcnt_d = dcnt_q - DcntW'(1);
      end
      default: ;
    endcase
  end

  assign fifo_pop   = out_valid && out_ready;
  assign fifo_push  = push_req && (!fifo_full || fifo_pop);
  assign fifo_wdata = '{amplitude: pk_q, timestamp: pk_ts_q};

  always_comb begin
    ts_cnt_d   = ts_cnt_q + TS_W'(1);
    x_d        = input_data;
    xts_d      = ts_cnt_q;
    overflow_d = overflow_q;
    drop_d     = drop_q;
    evcnt_d    = evcnt_q;
    if (push_req) begin
      evcnt_d = evcnt_q + 16'd1;
      if (!fifo_push) begin
        overflow_d = 1'b1;
        if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ts_cnt_q   <= '0;
      x_q        <= '0;
      xts_q      <= '0;
      pk_q       <= '0;
      pk_ts_q    <= '0;
      dcnt_q     <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
      evcnt_q    <= '0;
    end else begin
      ts_cnt_q   <= ts_cnt_d;
      x_q        <= x_d;
      xts_q      <= xts_d;
      pk_q       <= pk_d;
      pk_ts_q    <= pk_ts_d;
      dcnt_q     <= dcnt_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
      evcnt_q    <= evcnt_d;
    end
  end

  v9_event_fifo #(
    .DEPTH(FIFO_DEPTH),
    .T    (pk_event_t)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (fifo_push),
    .wdata(fifo_wdata),
    .pop  (fifo_pop),
    .rdata(fifo_rdata),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  assign out_valid     = !fifo_empty;
  assign out_amplitude = fifo_rdata.amplitude;
  assign out_timestamp = fifo_rdata.timestamp;
  assign overflow      = overflow_q;
  assign drop_count    = drop_q;
  assign event_count   = evcnt_q;

endmodule

// File: tb/tb_v9_peak_finder.sv
// Directed bench for v9_peak_finder: an event-level model checked every cycle,
// plus hand-computed expectations for each scenario.
module tb_v9_peak_finder;
  import v9_parameter::*;

  localparam int unsigned DW    = SIZE_ADC_DATA;
  localparam int unsigned TW    = V9_TS_W;
  localparam int          THR   = V9_PK_THRESHOLD;
  localparam int          REL   = (V9_PK_THRESHOLD > V9_PK_HYST) ?
                                  V9_PK_THRESHOLD - V9_PK_HYST : 0;
  localparam int          DEAD  = V9_PK_DEAD_TIME;
  localparam int          DEPTH = V9_PK_FIFO_DEPTH;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [DW-1:0] input_data = '0;
  logic          out_ready = 1'b0;
  logic          out_valid;
  logic [DW-1:0] out_amplitude;
  logic [TW-1:0] out_timestamp;
  logic          overflow;
  logic [15:0]   drop_count;
  logic [15:0]   event_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  v9_peak_finder dut (
    .clk          (clk),
    .reset        (reset),
    .input_data   (input_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_amplitude(out_amplitude),
    .out_timestamp(out_timestamp),
    .overflow     (overflow),
    .drop_count   (drop_count),
    .event_count  (event_count)
  );

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Event-level model: a pulse is a run from a sample >= THR until a sample < REL;
  // its event is the first maximum; the queue holds at most DEPTH events.
  typedef struct {
    int     amp;
    longint ts;
  } ev_t;

  ev_t    mq[$];
  int     m_mode;  // 0 waiting, 1 in pulse, 2 dead
  int     m_pk, m_dcnt, m_x, m_drop, m_evc;
  longint m_pkts, m_xts, m_ts;
  bit     m_ovf, m_pop, m_fire;
  int     edge_cnt;

  task automatic model_step();
    if (!reset) begin
      mq.delete();
      m_mode = 0; m_pk = 0; m_dcnt = 0; m_x = 0; m_drop = 0; m_evc = 0;
      m_pkts = 0; m_xts = 0; m_ts = 0; m_ovf = 0;
      edge_cnt = 0;
    end else begin
      m_pop  = (mq.size() > 0) && out_ready;
      m_fire = 0;
      if (m_mode == 0) begin
        if (m_x >= THR) begin m_mode = 1; m_pk = m_x; m_pkts = m_xts; end
      end else if (m_mode == 1) begin
        if (m_x > m_pk) begin m_pk = m_x; m_pkts = m_xts; end
        if (m_x < REL) begin
          m_fire = 1;
          m_mode = (DEAD == 0) ? 0 : 2;
          m_dcnt = DEAD;
        end
      end else begin
        if (m_dcnt > 0) m_dcnt--;
        else if (m_x < THR) m_mode = 0;
      end
      if (m_pop) void'(mq.pop_front());
      if (m_fire) begin
        m_evc = (m_evc + 1) % 65536;
        if (mq.size() < DEPTH) mq.push_back('{amp: m_pk, ts: m_pkts});
        else begin
          m_ovf = 1;
          if (m_drop < 65535) m_drop++;
        end
      end
      m_x   = int'(input_data);
      m_xts = m_ts;
      m_ts  = (m_ts + 1) % (64'd1 << TW);
      edge_cnt++;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
      #1;
      check("out_valid", out_valid, mq.size() > 0);
      if (mq.size() > 0) begin
        check("out_amplitude", out_amplitude, mq[0].amp);
        check("out_timestamp", out_timestamp, mq[0].ts);
      end
      check("overflow", overflow, m_ovf);
      check("drop_count", drop_count, m_drop);
      check("event_count", event_count, m_evc);
    end
  end

  task automatic drv(input int v);
    @(negedge clk);
    input_data = DW'(v);
  endtask

  task automatic idle(input int n);
    repeat (n) drv(0);
  endtask

  // Call right after driving the release sample.
  task automatic expect_event(input string nm, input int amp, input longint ts);
    @(posedge clk); #2;
    check({nm, "_valid_n1"}, out_valid, 0);
    @(posedge clk); #2;
    check({nm, "_valid_n2"}, out_valid, 1);
    check({nm, "_amp"}, out_amplitude, amp);
    check({nm, "_ts"}, out_timestamp, ts);
  endtask

  longint tpk;

  initial begin
    repeat (3) @(negedge clk);
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_amp", out_amplitude, 0);
    check("rst_ts", out_timestamp, 0);
    check("rst_overflow", overflow, 0);
    check("rst_drop", drop_count, 0);
    check("rst_events", event_count, 0);
    @(negedge clk);
    reset = 1'b1;
    out_ready = 1'b1;

    // 1: triangle, peak 500
    idle(3);
    tpk = 0;
    for (int v = 0; v <= 500; v += 50) begin
      drv(v);
      if (v == 500) tpk = edge_cnt;
    end
    for (int v = 450; v >= 100; v -= 50) drv(v);
    drv(50);
    expect_event("t1", 500, tpk);
    idle(25);

    // 2: flat top, first sample's timestamp wins
    drv(300);
    tpk = edge_cnt;
    repeat (4) drv(300);
    drv(0);
    expect_event("t2", 300, tpk);
    idle(25);

    // 3: sub-threshold pulse
    drv(50); drv(99); drv(50); drv(0);
    idle(25);
    check("t3_events", event_count, 2);
    check("t3_valid", out_valid, 0);

    // 4: hysteresis holds the pulse open across the dip to 95
    drv(120); drv(95);
    drv(130);
    tpk = edge_cnt;
    drv(95);
    drv(0);
    expect_event("t4", 130, tpk);
    idle(25);
    check("t4_events", event_count, 3);

    // 5: overflow with the consumer stalled
    out_ready = 1'b0;
    for (int a = 200; a <= 700; a += 100) begin
      drv(a);
      drv(0);
      idle(25);
    end
    check("t5_overflow", overflow, 1);
    check("t5_drop", drop_count, 2);
    check("t5_events", event_count, 9);
    check("t5_valid", out_valid, 1);
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    check("t5_drain0", out_amplitude, 200);
    for (int a = 300; a <= 500; a += 100) begin
      @(posedge clk); #2;
      check("t5_drain", out_amplitude, a);
    end
    @(posedge clk); #2;
    check("t5_empty", out_valid, 0);
    idle(5);

    // 6: re-arm inside dead time, then reset mid-pulse
    drv(300);
    drv(0);
    idle(4);
    drv(300);
    drv(0);
    idle(30);
    check("t6_events", event_count, 10);
    check("t6_overflow_sticky", overflow, 1);
    drv(300);
    drv(350);
    @(negedge clk);
    reset = 1'b0;
    input_data = '0;
    #1;
    check("t6_rst_valid", out_valid, 0);
    check("t6_rst_amp", out_amplitude, 0);
    check("t6_rst_ts", out_timestamp, 0);
    check("t6_rst_overflow", overflow, 0);
    check("t6_rst_drop", drop_count, 0);
    check("t6_rst_events", event_count, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    idle(20);
    check("t6_post_valid", out_valid, 0);
    check("t6_post_events", event_count, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
